// File: rtl/regfile_accum_ctrl.sv
// regfile_accum_ctrl
// Client-side controller for a 256x64 1W1R register file with a fixed
// 3-cycle registered read. Requests either add an operand to an entry or
// overwrite it. The new value is written back and reported on a response
// port. Because the register file has no reset, the controller zero-fills
// it after reset and again after a clear command.

module regfile_accum_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_op,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              rf_wena,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              resp_valid,
    output logic [ADDR_W-1:0] resp_addr,
    output logic [DATA_W-1:0] resp_data,
    output logic              init_done
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;

    state_t              r_state;
    state_t              w_nextState;
    logic [ADDR_W-1:0]   r_cnt;

    // Arms the zero-fill sweep. It stays low while reset is asserted, so the
    // write enable is quiet during reset even though the FSM already sits in
    // INIT. It is cleared only by reset, so a sweep that follows a clear
    // starts without the one-cycle delay.
    logic                r_armed;

    logic                r_s1Valid, r_s2Valid, r_s3Valid;
    logic                r_s1Op, r_s2Op, r_s3Op;
    logic [ADDR_W-1:0]   r_s1Addr, r_s2Addr, r_s3Addr;
    logic [DATA_W-1:0]   r_s1Data, r_s2Data, r_s3Data;

    logic                w_accept;
    logic                w_stagesEmpty;
    logic                w_sweepWrite;
    logic                w_inReady;
    logic                w_initDone;
    logic [DATA_W-1:0]   w_s3Result;

    assign w_accept      = in_valid && w_inReady;
    assign w_stagesEmpty = !(r_s1Valid || r_s2Valid || r_s3Valid);

    // The stage-3 result is a modulo-2^DATA_W sum for ADD and the operand
    // itself for WRITE. rf_rdata lines up with S3 because of the 3-cycle
    // read latency.
    assign w_s3Result = (r_s3Op == OP_ADD) ? (rf_rdata + r_s3Data) : r_s3Data;

    assign rf_raddr  = in_addr;
    assign in_ready  = w_inReady;
    assign init_done = w_initDone;

    // The sweep and stage 3 never write in the same cycle: INIT is entered
    // only once the pipeline has drained.
    assign rf_wena  = w_sweepWrite || r_s3Valid;
    assign rf_waddr = r_s3Valid ? r_s3Addr : r_cnt;
    assign rf_wdata = r_s3Valid ? w_s3Result : '0;

    // State register. Reset always returns to INIT.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic and handshake. A request is refused when the request
    // in S1 targets the same entry, because its write commits too late for
    // the new read to see it.
    always_comb begin
        w_nextState  = r_state;
        w_inReady    = 1'b0;
        w_initDone   = 1'b0;
        w_sweepWrite = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_sweepWrite = r_armed;
                if (r_armed && (r_cnt == {ADDR_W{1'b1}})) begin
                    w_nextState = ST_RUN;
                end
            end
            ST_RUN: begin
                w_initDone = 1'b1;
                w_inReady  = !clear && !(r_s1Valid && (r_s1Addr == in_addr));
                if (clear) begin
                    w_nextState = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_stagesEmpty) begin
                    w_nextState = ST_INIT;
                end
            end
            default: begin
                w_nextState = ST_INIT;
            end
        endcase
    end

    // The sweep arms one cycle after reset is released.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
        end
    end

    // The sweep counter advances once per INIT write. It rests at zero in
    // every other state, so each sweep starts at entry 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if ((r_state == ST_INIT) && r_armed) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    // The three pipeline stages cover the register-file read latency.
    // Requests keep moving during DRAIN until the pipeline is empty.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1Valid <= 1'b0;
            r_s2Valid <= 1'b0;
            r_s3Valid <= 1'b0;
            r_s1Op    <= 1'b0;
            r_s2Op    <= 1'b0;
            r_s3Op    <= 1'b0;
            r_s1Addr  <= '0;
            r_s2Addr  <= '0;
            r_s3Addr  <= '0;
            r_s1Data  <= '0;
            r_s2Data  <= '0;
            r_s3Data  <= '0;
        end else begin
            r_s1Valid <= w_accept;
            r_s1Op    <= in_op;
            r_s1Addr  <= in_addr;
            r_s1Data  <= in_data;
            r_s2Valid <= r_s1Valid;
            r_s2Op    <= r_s1Op;
            r_s2Addr  <= r_s1Addr;
            r_s2Data  <= r_s1Data;
            r_s3Valid <= r_s2Valid;
            r_s3Op    <= r_s2Op;
            r_s3Addr  <= r_s2Addr;
            r_s3Data  <= r_s2Data;
        end
    end

    // The response registers the stage-3 write, one cycle after the commit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            resp_valid <= 1'b0;
            resp_addr  <= '0;
            resp_data  <= '0;
        end else begin
            resp_valid <= r_s3Valid;
            resp_addr  <= r_s3Addr;
            resp_data  <= w_s3Result;
        end
    end

endmodule

// File: tb/tb_regfile_accum_ctrl.sv
// tb_regfile_accum_ctrl
// Directed testbench for regfile_accum_ctrl. A behavioural register file
// with a 3-cycle read latency surrounds the DUT. Stimulus pushes
// hand-computed responses into a scoreboard queue. A monitor pops the queue
// on every response pulse and compares address, data and latency.

module tb_regfile_accum_ctrl;

    localparam int AW = 8;
    localparam int DW = 64;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic          in_op;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic [AW-1:0] rf_raddr;
    logic [DW-1:0] rf_rdata;
    logic          rf_wena;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          resp_valid;
    logic [AW-1:0] resp_addr;
    logic [DW-1:0] resp_data;
    logic          init_done;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t expQ[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    always #5 clock = ~clock;

    regfile_accum_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .rf_raddr   (rf_raddr),
        .rf_rdata   (rf_rdata),
        .rf_wena    (rf_wena),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .resp_valid (resp_valid),
        .resp_addr  (resp_addr),
        .resp_data  (resp_data),
        .init_done  (init_done)
    );

    // Behavioural register file. The read address is delayed two cycles and
    // the array is sampled on the third edge, so a read sees every write
    // committed up to two edges after its address was presented.
    logic [DW-1:0] mem [256];
    logic [AW-1:0] rdA1, rdA2;

    always @(posedge clock) begin
        if (rf_wena) mem[rf_waddr] <= rf_wdata;
        rdA1     <= rf_raddr;
        rdA2     <= rdA1;
        rf_rdata <= mem[rdA2];
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every response pulse must match the oldest outstanding
    // expectation and arrive four cycles after acceptance.
    always @(negedge clock) begin
        exp_t e;
        if (reset_n && resp_valid) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_resp: got addr 0x%0h data 0x%0h, expected no response",
                         resp_addr, resp_data);
            end else begin
                e = expQ.pop_front();
                check("resp_addr", 64'(resp_addr), 64'(e.addr));
                check("resp_data", resp_data, e.data);
                check("resp_latency", 64'(cyc - e.cyc), 64'd4);
            end
        end
    end

    // Starts at a negedge. Holds the request until it is accepted, records
    // the expected response and returns at the negedge after acceptance.
    task automatic applyStimulus(input logic op, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] data, input logic [DW-1:0] expData,
                                 output int stalls);
        exp_t e;
        in_valid = 1'b1;
        in_op    = op;
        in_addr  = addr;
        in_data  = data;
        #1;
        stalls = 0;
        while (!in_ready && stalls < 50) begin
            @(negedge clock);
            #1;
            stalls++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got in_ready=0 after %0d cycles, expected acceptance", stalls);
        end else begin
            e.addr = addr;
            e.data = expData;
            e.cyc  = cyc;
            expQ.push_back(e);
        end
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic checkOutput(input string name);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        check(name, 64'(expQ.size()), 64'd0);
    endtask

    // Waits for the write of zero to entry 0, then expects 255 more
    // consecutive zero writes in address order. init_done and in_ready stay
    // low throughout, and init_done rises the next cycle.
    task automatic sweepCheck(input string name);
        int found, bad;
        found = 0;
        bad   = 0;
        for (int n = 0; n < 400 && found == 0; n++) begin
            @(negedge clock);
            if (rf_wena === 1'b1 && rf_waddr === 8'd0 && rf_wdata === 64'd0) found = 1;
        end
        check({name, "_sweep_start"}, 64'(found), 64'd1);
        for (int i = 1; i < 256; i++) begin
            @(negedge clock);
            if (!(rf_wena === 1'b1 && rf_waddr === 8'(i) && rf_wdata === 64'd0 &&
                  init_done === 1'b0 && in_ready === 1'b0)) bad++;
        end
        check({name, "_sweep_bad_cycles"}, 64'(bad), 64'd0);
        @(negedge clock);
        check({name, "_init_done"}, 64'(init_done), 64'd1);
        check({name, "_no_extra_write"}, 64'(rf_wena), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 1ms");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int st, total;
        reset_n  = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_op    = 1'b0;
        in_addr  = '0;
        in_data  = '0;
        repeat (3) @(negedge clock);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_rf_wena", 64'(rf_wena), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_init_done", 64'(init_done), 64'd0);
        reset_n = 1'b1;
        sweepCheck("init");

        // A WRITE followed by an ADD to the same entry costs one bubble.
        applyStimulus(1'b1, 8'd5, 64'h10, 64'h10, st);
        check("write5_stalls", 64'(st), 64'd0);
        applyStimulus(1'b0, 8'd5, 64'h3, 64'h13, st);
        check("add5_stalls", 64'(st), 64'd1);
        idle(1);
        checkOutput("drain_a");
        check("rf5_value", mem[5], 64'h13);

        // Distinct addresses flow at full rate.
        total = 0;
        for (int a = 1; a <= 4; a++) begin
            applyStimulus(1'b0, 8'(a), 64'd1, 64'd1, st);
            total += st;
        end
        check("distinct_stalls", 64'(total), 64'd0);
        idle(1);
        checkOutput("drain_b");

        // Modulo addition drops the carry.
        applyStimulus(1'b0, 8'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, st);
        applyStimulus(1'b0, 8'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, st);
        check("wrap_stalls", 64'(st), 64'd1);
        idle(1);
        checkOutput("drain_c");

        // Clear with three requests in flight. A request offered during
        // clear must not be taken.
        applyStimulus(1'b0, 8'd20, 64'd5, 64'd5, st);
        applyStimulus(1'b0, 8'd21, 64'd6, 64'd6, st);
        applyStimulus(1'b0, 8'd22, 64'd7, 64'd7, st);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_op    = 1'b1;
        in_addr  = 8'd30;
        in_data  = 64'h99;
        #1;
        check("clear_blocks_ready", 64'(in_ready), 64'd0);
        @(negedge clock);
        clear = 1'b0;
        #1;
        check("drain_blocks_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        sweepCheck("clear");
        check("clear_resps_done", 64'(expQ.size()), 64'd0);
        applyStimulus(1'b0, 8'd7, 64'd2, 64'd2, st);
        idle(1);
        checkOutput("drain_d");

        // Reset in the middle of the pipeline discards everything in flight.
        applyStimulus(1'b0, 8'd10, 64'd1, 64'd1, st);
        applyStimulus(1'b0, 8'd11, 64'd1, 64'd1, st);
        in_valid = 1'b0;
        @(posedge clock);
        #2;
        check("pre_reset_wena", 64'(rf_wena), 64'd1);
        reset_n = 1'b0;
        #1;
        check("reset_drops_wena", 64'(rf_wena), 64'd0);
        check("reset_drops_resp", 64'(resp_valid), 64'd0);
        expQ.delete();
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        sweepCheck("reset");
        applyStimulus(1'b0, 8'd10, 64'd4, 64'd4, st);
        idle(1);
        checkOutput("drain_e");
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_accum_ctrl.md
Name: regfile_accum_ctrl

Overview:
- Client-side controller that drives the read and write ports of a 256x64 1W1R register file (rf) with registered reads.
- Accepts accumulate/overwrite requests on a valid/ready port and issues the rf read.
- Waits the fixed 3-cycle rf read latency, then computes the new value, writes it back and reports it on a response port.
- Zero-fills the rf after reset and on a clear command, since the rf has no reset.

Parameters:
- ADDR_W, 8, rf address width; DEPTH = 2**ADDR_W.
- DATA_W, 64, rf data width.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- clear  in  1  pulse: drain the pipeline, then zero-fill the rf.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_op  in  1  0 = ADD (rf[a] += operand), 1 = WRITE (rf[a] = operand).
- in_addr  in  ADDR_W  target entry.
- in_data  in  DATA_W  operand.
- rf_raddr  out  ADDR_W  rf read address (combinational = in_addr).
- rf_rdata  in  DATA_W  rf read data, valid 3 cycles after the address is presented.
- rf_wena  out  1  rf write enable.
- rf_waddr  out  ADDR_W  rf write address.
- rf_wdata  out  DATA_W  rf write data.
- resp_valid  out  1  one-cycle pulse per completed request; no backpressure.
- resp_addr  out  ADDR_W  address of the completed request.
- resp_data  out  DATA_W  value written to the rf.
- init_done  out  1  high in RUN state.

Behaviour:
- FSM states: INIT, RUN, DRAIN.
  - Reset enters INIT.
  - INIT: counter 0..DEPTH-1, one write per cycle (rf_wena=1, waddr=counter, wdata=0). After writing entry DEPTH-1, go to RUN. Sweep takes 256 cycles.
  - RUN: normal operation. clear=1 in RUN -> DRAIN, and that cycle accepts no request.
  - DRAIN: in_ready=0. When stages S1..S3 are all empty -> INIT, counter=0.
  - clear is ignored in INIT and DRAIN.
- Reset values: in_ready=0, rf_wena=0, resp_valid=0, init_done=0, all stage valids 0, counter 0. Reset mid-operation discards in-flight requests and restarts INIT.
- Pipeline (RUN):
  - Accept in cycle t: rf_raddr=in_addr. S1 captures {op, addr, data} at edge t+1, S2 at edge t+2, S3 at edge t+3.
  - In the cycle S3 is valid: rf_wena=1, rf_waddr=S3.addr, rf_wdata = (op==ADD) ? rf_rdata+S3.data : S3.data.
  - Addition is modulo 2^DATA_W; carry is dropped.
  - resp_* registered from the write values: resp_valid is high in cycle t+4.
- Throughput: one request per cycle.
- Hazard: the rf read issued in cycle t sees only writes committed at edges up to t+2. A request accepted in cycle t-1 commits at edge t+3.
  - Rule: in_ready = (state==RUN) && !clear && !(S1.valid && S1.addr==in_addr).
  - Same-address back-to-back requests therefore get one bubble. Any address gap of two or more cycles is safe.
  - in_ready depends on in_addr. The producer must hold its request stable until accepted.
- Writes from INIT and from S3 never coincide, because the pipeline is empty in INIT.
- rf_raddr is don't-care when nothing is accepted.

Test Plan:
- Reset, hold 260 cycles -> exactly 256 writes of 0 to addresses 0..255 in order; init_done rises the cycle after the write to address 255; in_ready stays 0 until then.
- After init: WRITE a=5 d=0x10, then ADD a=5 d=0x3 in consecutive cycles -> in_ready=0 for one cycle on the ADD; resp_data = 0x10 then 0x13; rf[5]=0x13.
- ADD to a=1,2,3,4 every cycle with operand 1 -> no stalls; four resp pulses in consecutive cycles, each resp_data=1.
- ADD a=7 d=0xFFFF_FFFF_FFFF_FFFF twice (with the stall) -> second resp_data=0xFFFF_FFFF_FFFF_FFFE (wrap).
- clear while 3 requests are in flight -> all 3 responses still emitted; then a 256-entry zero sweep; an ADD a=7 d=2 afterwards -> resp_data=2.
- Assert reset_n mid-pipeline -> rf_wena and resp_valid drop immediately; no stale response after release; INIT restarts at address 0.
